rect_fill: RTL and testbench
============================

Name: rect_fill

Overview:
- Upstream drawing engine for the 320x240 RGB565 framebuffer.
- Accepts one filled-rectangle command at a time and emits one pixel write per cycle in raster order.
- Outputs drive the framebuffer write port directly: write enable, x, y, 16-bit pixel.
- Runs entirely in the framebuffer write-clock domain.

Parameters:
- DISPLAY_WIDTH, 320, framebuffer width in pixels.
- DISPLAY_HEIGHT, 240, framebuffer height in pixels.
- COLOR_WIDTH, 16, pixel width (RGB565).
- X_W, $clog2(DISPLAY_WIDTH) = 9, x coordinate width.
- Y_W, $clog2(DISPLAY_HEIGHT) = 8, y coordinate width.

Ports:
- wr_clk  input  1  sole clock; the framebuffer write clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine idle; command accepted on cmd_valid && cmd_ready.
- x0  input  X_W  corner A, x.
- y0  input  Y_W  corner A, y.
- x1  input  X_W  corner B, x.
- y1  input  Y_W  corner B, y.
- color  input  COLOR_WIDTH  fill colour.
- wr_grant  input  1  framebuffer write port available this cycle (arbiter); tie high if unshared.
- wr_en  output  1  pixel write strobe.
- x_out  output  X_W  write x.
- y_out  output  Y_W  write y.
- wr_out  output  COLOR_WIDTH  write data.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when the command completes.

Behaviour:
- Clock and reset: one clock, wr_clk; reset is synchronous and active-high on rst.
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, wr_en=0, x_out=0, y_out=0, wr_out=0.
- FSM states: IDLE, CLIP, FILL, DONE.
  - IDLE: cmd_ready=1. On cmd_valid, register the normalised command and go to CLIP.
    - xl=min(x0,x1), xr=max(x0,x1); likewise yt, yb.
    - Latch color.
  - CLIP (1 cycle):
    - If xl>=DISPLAY_WIDTH or yt>=DISPLAY_HEIGHT, go to DONE with zero writes.
    - Otherwise clamp xr to DISPLAY_WIDTH-1 and yb to DISPLAY_HEIGHT-1, load counters cx=xl, cy=yt, and go to FILL.
  - FILL:
    - wr_en = wr_grant (combinational); x_out=cx, y_out=cy, wr_out=latched color.
    - Counters advance only when wr_en is high: if cx==xr then cx<=xl, cy<=cy+1; else cx<=cx+1.
    - Writing (xr,yb) goes to DONE.
    - wr_grant low: hold cx/cy with wr_en=0; no pixel is skipped or repeated.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Bounds are inclusive; a degenerate rectangle (x0==x1, y0==y1) writes exactly one pixel.
- Width and arithmetic rules:
  - No counter wraps. cx compares against xr before incrementing, so cx+1 never exceeds 319.
  - Comparisons against DISPLAY_WIDTH/HEIGHT are done at X_W+1 / Y_W+1 bits.
  - Out-of-range input values (e.g. x=400, y=250) are legal and are clipped.
- Latency with wr_grant held high:
  - Accept at cycle T; first wr_en at T+2.
  - Last write at T+1+N, where N = clipped pixel count.
  - done at T+2+N.
- busy=1 in CLIP, FILL and DONE; cmd_ready = (state==IDLE).
  - cmd_valid while busy is ignored; the host must hold it.
  - A new command is accepted in the cycle after done.
- Reset mid-operation: next cycle is IDLE with wr_en=0, no done pulse, remaining pixels abandoned.
- Every pixel of a clipped rectangle is written exactly once; nothing outside it is ever written.

Decomposition:
- Shared package gfx_pkg:
  - DISPLAY_WIDTH, DISPLAY_HEIGHT, COLOR_WIDTH, X_W, Y_W.
  - rect_fill_state_t enum {IDLE, CLIP, FILL, DONE}.
  - Packed struct rect_cmd_t {x0, y0, x1, y1, color}.
- Single module; no sub-module. Normalisation and clamping are small enough to stay inline.

Test Plan:
- 3x2 rectangle: (10,5)-(12,6), color 16'hF800, wr_grant=1 -> 6 writes in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), first at accept+2, done at accept+8, busy high 8 cycles.
- Swapped corners: (12,6)-(10,5) -> identical write sequence to the previous test.
- Clipping: (318,238)-(400,250) -> 4 writes (318,238),(319,238),(318,239),(319,239). Fully off-screen (330,0)-(340,10) -> zero writes, done at accept+2.
- Backpressure: 2x1 rectangle with wr_grant low for 3 cycles mid-fill -> wr_en=0 and coordinates held during the stall, exactly 2 writes, done delayed by 3 cycles.
- Reset after 2 of 6 writes -> wr_en=0 and cmd_ready=1 the next cycle, no done; a new 1x1 command at (0,0) then completes normally.
- Back-to-back commands with cmd_valid held -> second command accepted the cycle after the first done; cmd_ready=0 throughout the first.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared framebuffer geometry, colour format and drawing-command types
// for the 320x240 RGB565 graphics path.
package gfx_pkg;

    localparam int DISPLAY_WIDTH  = 320;
    localparam int DISPLAY_HEIGHT = 240;
    localparam int COLOR_WIDTH    = 16;
    localparam int X_W            = $clog2(DISPLAY_WIDTH);
    localparam int Y_W            = $clog2(DISPLAY_HEIGHT);

    // Limits widened by one bit so off-screen inputs compare correctly.
    localparam logic [X_W:0]   X_LIMIT = (X_W+1)'(DISPLAY_WIDTH);
    localparam logic [Y_W:0]   Y_LIMIT = (Y_W+1)'(DISPLAY_HEIGHT);
    localparam logic [X_W-1:0] X_MAX   = X_W'(DISPLAY_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(DISPLAY_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } rect_fill_state_t;

    typedef struct packed {
        logic [X_W-1:0]         x0;
        logic [Y_W-1:0]         y0;
        logic [X_W-1:0]         x1;
        logic [Y_W-1:0]         y1;
        logic [COLOR_WIDTH-1:0] color;
    } rect_cmd_t;

endpackage

// File: rtl/rect_fill.sv
// Filled-rectangle engine: normalises and clips one command, then streams
// one framebuffer pixel write per granted cycle in raster order.
module rect_fill
    import gfx_pkg::*;
(
    input  logic                   wr_clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [X_W-1:0]         x0,
    input  logic [Y_W-1:0]         y0,
    input  logic [X_W-1:0]         x1,
    input  logic [Y_W-1:0]         y1,
    input  logic [COLOR_WIDTH-1:0] color,
    input  logic                   wr_grant,
    output logic                   wr_en,
    output logic [X_W-1:0]         x_out,
    output logic [Y_W-1:0]         y_out,
    output logic [COLOR_WIDTH-1:0] wr_out,
    output logic                   busy,
    output logic                   done
);

    rect_cmd_t              cmd_s;
    rect_fill_state_t       state_q, state_d;
    logic [X_W-1:0]         xl_q, xl_d, xr_q, xr_d, cx_q, cx_d;
    logic [Y_W-1:0]         yt_q, yt_d, yb_q, yb_d, cy_q, cy_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic                   cmd_ready_q, busy_q, done_q;

    assign cmd_s = '{x0: x0, y0: y0, x1: x1, y1: y1, color: color};

    // Next-state and datapath: normalise on accept, clip once, then walk the rectangle.
    always_comb begin
        state_d = state_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        yt_d    = yt_q;
        yb_d    = yb_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        color_d = color_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    xl_d    = (cmd_s.x0 < cmd_s.x1) ? cmd_s.x0 : cmd_s.x1;
                    xr_d    = (cmd_s.x0 < cmd_s.x1) ? cmd_s.x1 : cmd_s.x0;
                    yt_d    = (cmd_s.y0 < cmd_s.y1) ? cmd_s.y0 : cmd_s.y1;
                    yb_d    = (cmd_s.y0 < cmd_s.y1) ? cmd_s.y1 : cmd_s.y0;
                    color_d = cmd_s.color;
                    state_d = CLIP;
                end else begin
                    state_d = IDLE;
                end
            end
            CLIP: begin
                if (({1'b0, xl_q} >= X_LIMIT) || ({1'b0, yt_q} >= Y_LIMIT)) begin
                    state_d = DONE;
                end else begin
                    xr_d    = ({1'b0, xr_q} >= X_LIMIT) ? X_MAX : xr_q;
                    yb_d    = ({1'b0, yb_q} >= Y_LIMIT) ? Y_MAX : yb_q;
                    cx_d    = xl_q;
                    cy_d    = yt_q;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Counters move only on an accepted write, so a stall never skips a pixel.
                if (wr_grant) begin
                    if (cx_q == xr_q) begin
                        if (cy_q == yb_q) begin
                            state_d = DONE;
                        end else begin
                            cx_d = xl_q;
                            cy_d = cy_q + Y_W'(1);
                        end
                    end else begin
                        cx_d = cx_q + X_W'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, command, counter and status registers.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            xl_q        <= '0;
            xr_q        <= '0;
            yt_q        <= '0;
            yb_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            color_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xl_q        <= xl_d;
            xr_q        <= xr_d;
            yt_q        <= yt_d;
            yb_q        <= yb_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            color_q     <= color_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    // The write strobe follows the arbiter grant directly while filling.
    assign wr_en     = (state_q == FILL) && wr_grant;
    assign x_out     = cx_q;
    assign y_out     = cy_q;
    assign wr_out    = color_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rect_fill.sv
// Bench for rect_fill: directed vector table, reset and back-to-back
// sequences, and randomized rectangles checked against a pixel-list model.
module tb_rect_fill;
    import gfx_pkg::*;

    logic                   wr_clk = 1'b0;
    logic                   rst, cmd_valid, cmd_ready, wr_grant, wr_en, busy, done;
    logic [X_W-1:0]         x0, x1, x_out;
    logic [Y_W-1:0]         y0, y1, y_out;
    logic [COLOR_WIDTH-1:0] color, wr_out;

    always #5 wr_clk = ~wr_clk;

    rect_fill dut (
        .wr_clk(wr_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .wr_grant(wr_grant),
        .wr_en(wr_en), .x_out(x_out), .y_out(y_out), .wr_out(wr_out),
        .busy(busy), .done(done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int exp_x[$];
    int exp_y[$];

    typedef struct {
        int x0, y0, x1, y1;
        int color;
        int st_start, st_len;
        int exp_n, exp_done;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected pixels: inclusive normalised bounds, clipped to the screen, raster order.
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int xl, xr, yt, yb;
        exp_x.delete();
        exp_y.delete();
        xl = (ax0 < ax1) ? ax0 : ax1;
        xr = (ax0 < ax1) ? ax1 : ax0;
        yt = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        if (xl < DISPLAY_WIDTH && yt < DISPLAY_HEIGHT) begin
            if (xr > DISPLAY_WIDTH - 1)  xr = DISPLAY_WIDTH - 1;
            if (yb > DISPLAY_HEIGHT - 1) yb = DISPLAY_HEIGHT - 1;
            for (int y = yt; y <= yb; y++)
                for (int x = xl; x <= xr; x++) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
        end
    endtask

    task automatic run_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input int st_start, input int st_len,
                            input bit rnd, output int n_wr, output int done_k);
        int idx = 0;
        int k = 0;
        int busy_cnt = 0;
        int exp_done;
        bit g;
        build_model(ax0, ay0, ax1, ay1);
        exp_done = (exp_x.size() == 0) ? 2 : -1;
        n_wr = 0;
        done_k = -1;
        @(negedge wr_clk);
        x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
        color = COLOR_WIDTH'(col); cmd_valid = 1'b1; wr_grant = 1'b1;
        #1;
        check("accept_ready", cmd_ready, 1);
        while (done_k < 0 && k < 2000) begin
            k++;
            @(negedge wr_clk);
            cmd_valid = 1'b0;
            if (rnd) g = ($urandom_range(3) != 0);
            else     g = !(k >= st_start && k < st_start + st_len);
            wr_grant = g;
            #1;
            if (busy) busy_cnt++;
            if (wr_en) n_wr++;
            check("ready_low_while_busy", cmd_ready, 0);
            if (k >= 2 && idx < exp_x.size()) begin
                check("wr_en_follows_grant", wr_en, g);
                check("x_out", x_out, exp_x[idx]);
                check("y_out", y_out, exp_y[idx]);
                if (g) begin
                    check("wr_out", wr_out, col);
                    idx++;
                    if (idx == exp_x.size()) exp_done = k + 1;
                end
            end else begin
                check("no_write_outside_fill", wr_en, 0);
            end
            if (done) done_k = k;
        end
        check("done_cycle", done_k, exp_done);
        check("busy_cycles", busy_cnt, done_k);
        check("write_count", n_wr, exp_x.size());
        @(negedge wr_clk);
        wr_grant = 1'b1;
        #1;
        check("done_one_cycle", done, 0);
        check("ready_after_done", cmd_ready, 1);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        vec_t tbl[8];
        int n_wr, done_k;
        int wr_cnt, first_done, accept_b, done_b;
        int rx0, ry0, rx1, ry1;

        tbl[0] = '{10, 5, 12, 6, 16'hF800, 0, 0, 6, 8};
        tbl[1] = '{12, 6, 10, 5, 16'hF800, 0, 0, 6, 8};
        tbl[2] = '{318, 238, 400, 250, 16'h07E0, 0, 0, 4, 6};
        tbl[3] = '{330, 0, 340, 10, 16'h001F, 0, 0, 0, 2};
        tbl[4] = '{20, 20, 21, 20, 16'h1234, 3, 3, 2, 7};
        tbl[5] = '{5, 5, 5, 5, 16'hFFFF, 0, 0, 1, 3};
        tbl[6] = '{0, 240, 5, 250, 16'hAAAA, 0, 0, 0, 2};
        tbl[7] = '{319, 0, 319, 239, 16'h5555, 0, 0, 240, 242};

        rst = 1'b1; cmd_valid = 1'b0; wr_grant = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (3) @(negedge wr_clk);
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_wr_out", wr_out, 0);

        for (int i = 0; i < 8; i++) begin
            run_rect(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].color,
                     tbl[i].st_start, tbl[i].st_len, 1'b0, n_wr, done_k);
            check($sformatf("vec%0d_writes", i), n_wr, tbl[i].exp_n);
            check($sformatf("vec%0d_done", i), done_k, tbl[i].exp_done);
        end

        // Reset after two of six writes abandons the rectangle.
        @(negedge wr_clk);
        x0 = 9'd10; y0 = 8'd5; x1 = 9'd12; y1 = 8'd6; color = 16'hF800;
        cmd_valid = 1'b1; wr_grant = 1'b1;
        wr_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge wr_clk);
            cmd_valid = 1'b0;
            #1;
            if (wr_en) wr_cnt++;
        end
        check("pre_reset_writes", wr_cnt, 2);
        @(negedge wr_clk);
        rst = 1'b1;
        @(negedge wr_clk);
        rst = 1'b0;
        #1;
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        wr_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge wr_clk);
            #1;
            if (done || wr_en) wr_cnt++;
        end
        check("post_rst_quiet", wr_cnt, 0);
        run_rect(0, 0, 0, 0, 16'hBEEF, 0, 0, 1'b0, n_wr, done_k);
        check("post_rst_1x1_writes", n_wr, 1);

        // Back-to-back: the host holds cmd_valid across the first command.
        @(negedge wr_clk);
        x0 = 9'd1; y0 = 8'd1; x1 = 9'd2; y1 = 8'd1; color = 16'h0F0F;
        cmd_valid = 1'b1; wr_grant = 1'b1;
        #1;
        check("b2b_accept_a", cmd_ready, 1);
        first_done = -1; accept_b = -1; done_b = -1; wr_cnt = 0;
        for (int k = 1; k <= 40 && done_b < 0; k++) begin
            @(negedge wr_clk);
            if (accept_b >= 0) cmd_valid = 1'b0;
            x0 = 9'd7; y0 = 8'd7; x1 = 9'd7; y1 = 8'd8; color = 16'hF0F0;
            #1;
            if (wr_en) wr_cnt++;
            if (first_done < 0) check("b2b_ready_low_a", cmd_ready, 0);
            if (done && first_done >= 0 && k > first_done) done_b = k;
            if (done && first_done < 0) first_done = k;
            if (cmd_ready && cmd_valid && accept_b < 0) accept_b = k;
        end
        cmd_valid = 1'b0;
        check("b2b_done_a", first_done, 4);
        check("b2b_accept_b", accept_b, 5);
        check("b2b_done_b", done_b, 9);
        check("b2b_writes", wr_cnt, 4);

        // Randomized rectangles with random arbiter grants, biased towards the screen edges.
        for (int i = 0; i < 40; i++) begin
            rx0 = (i % 2 == 0) ? $urandom_range(300, 335) : $urandom_range(0, 511);
            ry0 = (i % 3 == 0) ? $urandom_range(225, 255) : $urandom_range(0, 255);
            rx1 = rx0 + $urandom_range(0, 20) - 10;
            ry1 = ry0 + $urandom_range(0, 12) - 6;
            if (rx1 < 0) rx1 = 0;
            if (rx1 > 511) rx1 = 511;
            if (ry1 < 0) ry1 = 0;
            if (ry1 > 255) ry1 = 255;
            run_rect(rx0, ry0, rx1, ry1, $urandom_range(0, 65535), 0, 0, 1'b1, n_wr, done_k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
